// File: rtl/execute_cc_stage.sv
// Y-86 execute stage: registered ALU result and branch/move condition,
// with the condition-code register (ZF/SF/OF) owned locally.
module execute_cc_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val_a,
    input  logic [WIDTH-1:0] val_b,
    input  logic [3:0]       alu_fun,
    input  logic             set_cc,
    input  logic [2:0]       cond_fun,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val_e,
    output logic             cnd,
    output logic             fun_err,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_XOR = 4'd3
    } alu_fun_e;

    typedef enum logic [2:0] {
        C_ALWAYS  = 3'd0,
        C_LE      = 3'd1,
        C_L       = 3'd2,
        C_E       = 3'd3,
        C_NE      = 3'd4,
        C_GE      = 3'd5,
        C_G       = 3'd6,
        C_ILLEGAL = 3'd7
    } cond_fun_e;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] val_e_q, val_e_d;
    logic             cnd_q, cnd_d;
    logic             fun_err_q, fun_err_d;
    logic             cc_zf_q, cc_zf_d;
    logic             cc_sf_q, cc_sf_d;
    logic             cc_of_q, cc_of_d;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_of;
    logic             alu_err;
    logic             cond_res;
    logic             cond_err;
    logic             sf_xor_of;

    // Single output register, no skid: we can take new data whenever the
    // slot is empty or is being drained this same cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // ALU: result and overflow flag, both operands taken as valB op valA.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case, so no path leaves it unassigned and no latch is inferred.
        alu_res = '0;
        alu_of  = 1'b0;
        alu_err = 1'b0;
        case (alu_fun)
            ALU_ADD: begin
                alu_res = val_b + val_a;
                alu_of  = (val_a[WIDTH-1] == val_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != val_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = val_b - val_a;
                alu_of  = (val_b[WIDTH-1] != val_a[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != val_b[WIDTH-1]);
            end
            ALU_AND: alu_res = val_b & val_a;
            ALU_XOR: alu_res = val_b ^ val_a;
            default: alu_err = 1'b1;
        endcase
    end

    // Condition evaluation against the CC contents before this edge's update.
    always_comb begin
        sf_xor_of = cc_sf_q ^ cc_of_q;
        cond_res  = 1'b0;
        cond_err  = 1'b0;
        case (cond_fun)
            C_ALWAYS: cond_res = 1'b1;
            C_LE:     cond_res = sf_xor_of || cc_zf_q;
            C_L:      cond_res = sf_xor_of;
            C_E:      cond_res = cc_zf_q;
            C_NE:     cond_res = !cc_zf_q;
            C_GE:     cond_res = !sf_xor_of;
            C_G:      cond_res = !sf_xor_of && !cc_zf_q;
            C_ILLEGAL: cond_err = 1'b1;
            default:  cond_err = 1'b1;
        endcase
    end

    // Next-state for the output register and the CC register; hold by default.
    always_comb begin
        out_valid_d = out_valid_q;
        val_e_d     = val_e_q;
        cnd_d       = cnd_q;
        fun_err_d   = fun_err_q;
        cc_zf_d     = cc_zf_q;
        cc_sf_d     = cc_sf_q;
        cc_of_d     = cc_of_q;

        if (accept) begin
            out_valid_d = 1'b1;
            val_e_d     = alu_res;
            cnd_d       = cond_res;
            fun_err_d   = alu_err || cond_err;
            if (set_cc && !alu_err) begin
                cc_zf_d = (alu_res == '0);
                cc_sf_d = alu_res[WIDTH-1];
                cc_of_d = alu_of;
            end
        end else if (out_valid_q && out_ready) begin
            // Drained with nothing behind it; val_e keeps its last value.
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset empties the output slot and restores ZF=1.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of order.
        if (rst) begin
            out_valid_q <= 1'b0;
            val_e_q     <= '0;
            cnd_q       <= 1'b0;
            fun_err_q   <= 1'b0;
            cc_zf_q     <= 1'b1;
            cc_sf_q     <= 1'b0;
            cc_of_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            val_e_q     <= val_e_d;
            cnd_q       <= cnd_d;
            fun_err_q   <= fun_err_d;
            cc_zf_q     <= cc_zf_d;
            cc_sf_q     <= cc_sf_d;
            cc_of_q     <= cc_of_d;
        end
    end

    assign out_valid = out_valid_q;
    assign val_e     = val_e_q;
    assign cnd       = cnd_q;
    assign fun_err   = fun_err_q;
    assign cc_zf     = cc_zf_q;
    assign cc_sf     = cc_sf_q;
    assign cc_of     = cc_of_q;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Bench for execute_cc_stage: vector table plus hand-written stall and
// reset sequences, results checked through an in-order scoreboard.
module tb_execute_cc_stage;

    localparam int WIDTH = 64;
    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M5 = 64'hFFFF_FFFF_FFFF_FFFB;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic [3:0]       alu_fun;
    logic             set_cc;
    logic [2:0]       cond_fun;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] val_e;
    logic             cnd;
    logic             fun_err;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;

    typedef struct {
        logic [3:0]  fun;
        logic [2:0]  cond;
        logic        set;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_e;
        logic        exp_cnd;
        logic        exp_err;
        logic [2:0]  exp_cc;   // {ZF,SF,OF} after this instruction
    } vec_t;

    typedef struct {
        int          id;
        logic [63:0] e;
        logic        cnd;
        logic        err;
        logic [2:0]  cc;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    execute_cc_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .val_a(val_a), .val_b(val_b), .alu_fun(alu_fun),
        .set_cc(set_cc), .cond_fun(cond_fun),
        .out_valid(out_valid), .out_ready(out_ready),
        .val_e(val_e), .cnd(cnd), .fun_err(fun_err),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_fun  = v.fun;
        cond_fun = v.cond;
        set_cc   = v.set;
        val_a    = v.a;
        val_b    = v.b;
        in_valid = 1'b1;
    endtask

    function automatic exp_t to_exp(input vec_t v, input int id);
        exp_t x;
        x.id  = id;
        x.e   = v.exp_e;
        x.cnd = v.exp_cnd;
        x.err = v.exp_err;
        x.cc  = v.exp_cc;
        return x;
    endfunction

    // Drive one instruction from posedge+1 and wait (bounded) until accepted.
    task automatic issue(input vec_t v, input int id);
        int  budget;
        logic done;
        budget = 0;
        done   = 1'b0;
        drive(v);
        sb.push_back(to_exp(v, id));
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout_%0d: actual in_ready=0 required 1", id);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t va, vb, vc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        val_a = '0; val_b = '0; alu_fun = '0; set_cc = 1'b0; cond_fun = '0;

        //          fun   cond  set  a      b      exp_e                 cnd   err   cc
        vecs[0]  = '{4'd1, 3'd0, 1'b1, 64'd1, 64'd5, 64'd4,               1'b1, 1'b0, 3'b000};
        vecs[1]  = '{4'd1, 3'd0, 1'b1, M5,    M1,    64'd4,               1'b1, 1'b0, 3'b000};
        vecs[2]  = '{4'd1, 3'd3, 1'b1, M5,    MAXP,  64'h8000_0000_0000_0004, 1'b0, 1'b0, 3'b011};
        vecs[3]  = '{4'd0, 3'd2, 1'b0, 64'd0, 64'd0, 64'd0,               1'b0, 1'b0, 3'b011};
        vecs[4]  = '{4'd1, 3'd3, 1'b1, 64'd3, 64'd3, 64'd0,               1'b0, 1'b0, 3'b100};
        vecs[5]  = '{4'd0, 3'd3, 1'b0, 64'd1, 64'd2, 64'd3,               1'b1, 1'b0, 3'b100};
        vecs[6]  = '{4'd0, 3'd4, 1'b1, 64'd1, MAXP,  64'h8000_0000_0000_0000, 1'b0, 1'b0, 3'b011};
        vecs[7]  = '{4'd2, 3'd1, 1'b1, 64'hFF00, 64'hF0F0, 64'hF000,      1'b0, 1'b0, 3'b000};
        vecs[8]  = '{4'd3, 3'd5, 1'b1, 64'd0, M1,    M1,                  1'b1, 1'b0, 3'b010};
        vecs[9]  = '{4'd9, 3'd6, 1'b1, 64'd5, 64'd5, 64'd0,               1'b0, 1'b1, 3'b010};
        vecs[10] = '{4'd0, 3'd7, 1'b0, 64'd0, 64'd0, 64'd0,               1'b0, 1'b1, 3'b010};
        vecs[11] = '{4'd0, 3'd2, 1'b0, 64'd3, 64'd2, 64'd5,               1'b1, 1'b0, 3'b010};
        vecs[12] = '{4'd3, 3'd1, 1'b1, 64'd5, 64'd5, 64'd0,               1'b1, 1'b0, 3'b100};
        vecs[13] = '{4'd1, 3'd6, 1'b1, 64'd2, 64'd1, M1,                  1'b0, 1'b0, 3'b010};
        vecs[14] = '{4'd0, 3'd5, 1'b0, 64'd0, 64'd0, 64'd0,               1'b0, 1'b0, 3'b010};

        fork
            // Scoreboard monitor: a result leaves on the edge after a negedge
            // at which out_valid & out_ready are both seen.
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: actual val_e=%h required no output", val_e);
                    end else begin
                        exp_t x;
                        x = sb.pop_front();
                        check($sformatf("v%0d_val_e", x.id), val_e, x.e);
                        check($sformatf("v%0d_cnd", x.id), 64'(cnd), 64'(x.cnd));
                        check($sformatf("v%0d_fun_err", x.id), 64'(fun_err), 64'(x.err));
                        check($sformatf("v%0d_cc", x.id), 64'({cc_zf, cc_sf, cc_of}), 64'(x.cc));
                    end
                end
            end

            begin
                #200000;
                $display("FAIL watchdog: actual timeout required completion");
                $fatal(1, "watchdog expired");
            end

            begin
                // Reset state.
                repeat (2) @(posedge clk);
                #1;
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_val_e", val_e, 64'd0);
                check("rst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
                rst = 1'b0;
                #1;
                check("rst_in_ready", 64'(in_ready), 64'd1);

                // Back-to-back table at full throughput.
                for (int i = 0; i < 15; i++) issue(vecs[i], i);
                idle(3);
                check("table_drained", 64'(sb.size()), 64'd0);

                // Backpressure: A loads while downstream stalls, B waits 3 cycles.
                va = '{4'd0, 3'd0, 1'b1, 64'd10, 64'd20, 64'd30, 1'b1, 1'b0, 3'b000};
                vb = '{4'd1, 3'd4, 1'b1, 64'd2, 64'd1, M1, 1'b1, 1'b0, 3'b010};
                out_ready = 1'b0;
                drive(va);
                sb.push_back(to_exp(va, 100));
                @(negedge clk);
                check("bp_a_in_ready", 64'(in_ready), 64'd1);
                @(posedge clk);
                #1;
                drive(vb);
                sb.push_back(to_exp(vb, 101));
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
                    check($sformatf("bp_val_e_%0d", i), val_e, 64'd30);
                    check($sformatf("bp_cc_%0d", i), 64'({cc_zf, cc_sf, cc_of}), 64'b000);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);     // A leaves, B loads on this edge
                #1;
                in_valid = 1'b0;
                @(posedge clk);     // B leaves, nothing behind it
                #1;
                @(negedge clk);
                check("drain_out_valid", 64'(out_valid), 64'd0);
                check("drain_val_e_kept", val_e, M1);
                check("bp_drained", 64'(sb.size()), 64'd0);

                // Asynchronous reset mid-stream with a held result.
                vc = '{4'd0, 3'd0, 1'b1, 64'd7, 64'd8, 64'd15, 1'b1, 1'b0, 3'b000};
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                drive(vc);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                @(negedge clk);
                check("pre_rst_out_valid", 64'(out_valid), 64'd1);
                check("pre_rst_val_e", val_e, 64'd15);
                #2;
                rst = 1'b1;
                #1;
                check("async_rst_out_valid", 64'(out_valid), 64'd0);
                check("async_rst_val_e", val_e, 64'd0);
                check("async_rst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
                check("async_rst_fun_err", 64'(fun_err), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                out_ready = 1'b1;
                #1;
                check("post_rst_in_ready", 64'(in_ready), 64'd1);
                @(posedge clk);
                #1;
                issue(vecs[0], 200);
                idle(3);
                check("final_drained", 64'(sb.size()), 64'd0);
            end
        join_any
        disable fork;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
